// File: rtl/cla_subtractor_pipe.sv
// Pipelined A - B subtractor: one carry-lookahead chunk resolved per stage, borrow chain
// carried between stages in registers, global stall driven by the output handshake.
`timescale 1ns/1ps
module cla_subtractor_pipe #(
  parameter int N     = 8,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         overflow,
  output logic         zero
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int STAGES     = N / CHUNK_SAFE;
  localparam int LAST       = STAGES - 1;

  generate
    if (CHUNK < 1 || (N % CHUNK_SAFE) != 0 || STAGES < 1) begin : g_bad_cfg
      $error("cla_subtractor_pipe: N must be a positive multiple of CHUNK (CHUNK >= 1)");
    end
  endgenerate

  // Returns {carry_out, sum} of a + ~b + cin, every carry expanded as a full lookahead term.
  function automatic logic [CHUNK_SAFE:0] cla_chunk(
    input logic [CHUNK_SAFE-1:0] a,
    input logic [CHUNK_SAFE-1:0] b,
    input logic                  cin
  );
    logic [CHUNK_SAFE-1:0] g;
    logic [CHUNK_SAFE-1:0] p;
    logic [CHUNK_SAFE:0]   c;
    logic                  t;
    g = a & ~b;
    p = a ^ ~b;
    for (int i = 0; i <= CHUNK_SAFE; i++) begin
      t = cin;
      for (int j = 0; j < i; j++) t = t & p[j];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    cla_chunk = {c[CHUNK_SAFE], p ^ c[CHUNK_SAFE-1:0]};
  endfunction

  function automatic logic ovf_flag(input logic sa, input logic sb, input logic sd);
    ovf_flag = (sa ^ sb) & (sa ^ sd);
  endfunction

  logic                 w_en;
  logic [STAGES-1:0]    r_vld;
  logic [N-1:0]         r_d  [STAGES];
  logic [N-1:0]         r_a  [STAGES];
  logic [N-1:0]         r_b  [STAGES];
  logic [STAGES-1:0]    r_c;
  logic [STAGES-1:0]    r_sa;
  logic [STAGES-1:0]    r_sb;
  logic [N-1:0]         w_d  [STAGES];
  logic [CHUNK_SAFE:0]  w_res[STAGES];
  logic                 w_unused;

  assign w_en      = ~r_vld[LAST] | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld[LAST];

  // Chunk k is resolved from the operands carried in stage k-1 (stage 0 takes the ports).
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_d[k]   = '0;
      w_res[k] = '0;
    end
    w_res[0]                   = cla_chunk(A[CHUNK_SAFE-1:0], B[CHUNK_SAFE-1:0], 1'b1);
    w_d[0][CHUNK_SAFE-1:0]     = w_res[0][CHUNK_SAFE-1:0];
    for (int k = 1; k < STAGES; k++) begin
      w_res[k] = cla_chunk(r_a[k-1][k*CHUNK_SAFE +: CHUNK_SAFE],
                           r_b[k-1][k*CHUNK_SAFE +: CHUNK_SAFE], r_c[k-1]);
      w_d[k]   = r_d[k-1];
      w_d[k][k*CHUNK_SAFE +: CHUNK_SAFE] = w_res[k][CHUNK_SAFE-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else if (w_en) begin
      r_vld[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) r_vld[k] <= r_vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_d[0]  <= w_d[0];
      r_c[0]  <= w_res[0][CHUNK_SAFE];
      r_a[0]  <= A;
      r_b[0]  <= B;
      r_sa[0] <= A[N-1];
      r_sb[0] <= B[N-1];
      for (int k = 1; k < STAGES; k++) begin
        r_d[k]  <= w_d[k];
        r_c[k]  <= w_res[k][CHUNK_SAFE];
        r_a[k]  <= r_a[k-1];
        r_b[k]  <= r_b[k-1];
        r_sa[k] <= r_sa[k-1];
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  // Final stage: flags derived from the last register, forced to 0 while no result is valid.
  assign diff     = out_valid ? r_d[LAST] : '0;
  assign borrow   = out_valid & ~r_c[LAST];
  assign overflow = out_valid & ovf_flag(r_sa[LAST], r_sb[LAST], r_d[LAST][N-1]);
  assign zero     = out_valid & (r_d[LAST] == '0);

  assign w_unused = ^{r_a[LAST], r_b[LAST]};

endmodule
